// File: rtl/wram_hs_arbiter.sv
`default_nettype none
// ============================================================================
// wram_hs_arbiter : shares the single-port CPU work RAM with the hiscore engine
// Revision 1.0 - initial release
// ============================================================================
module wram_hs_arbiter #(
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] RAM_BASE   = 16'h8000,
  parameter int          HS_TIMEOUT = 4096
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  input  logic              hs_req,
  output logic [7:0]        hs_data_out,
  output logic              hs_grant,
  output logic              hs_timeout
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              WD_W    = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(HS_TIMEOUT - 1);

  localparam logic [1:0] CPU_OWN  = 2'd0;
  localparam logic [1:0] HS_OWN   = 2'd1;
  localparam logic [1:0] HS_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nx;
  logic [WD_W-1:0]   r_wd;
  logic              r_block;
  logic              r_timeout;
  logic [ADDR_W-1:0] r_hs_addr_last;
  logic              r_cpu_pend;
  logic              r_hs_pend;
  logic              r_hs_oow;
  logic [7:0]        r_cpu_hold;
  logic [7:0]        r_hs_hold;
  logic [7:0]        r_rdata;
  logic [7:0]        mem [DEPTH];

  logic [15:0]       w_hs_off;
  logic              w_hs_in;
  logic              w_fire;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_we;
  logic [7:0]        w_hs_rd;

  assign w_hs_off = hs_address - RAM_BASE;
  assign w_hs_in  = (w_hs_off[15:ADDR_W] == '0);
  assign w_fire   = (r_state == HS_OWN) && (r_wd == WD_LAST);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      CPU_OWN:  if (hs_req && !cpu_cs && !r_block) w_state_nx = HS_OWN;
      HS_OWN:   if (!hs_req || w_fire) w_state_nx = HS_DRAIN;
      default:  w_state_nx = CPU_OWN;
    endcase
  end

  // RAM port steering; writes are gated by reset so an asserted reset can
  // never let a half-finished hiscore write land in the array.
  always_comb begin
    w_addr  = cpu_addr;
    w_wdata = cpu_din;
    w_we    = cpu_cs & cpu_wr;
    case (r_state)
      HS_OWN: begin
        w_addr  = w_hs_off[ADDR_W-1:0];
        w_wdata = hs_data_in;
        w_we    = hs_write & w_hs_in;
      end
      HS_DRAIN: begin
        w_addr = r_hs_addr_last;
        w_we   = 1'b0;
      end
      default: ;
    endcase
    w_we = w_we & reset;
  end

  always_ff @(posedge clk_49m) begin
    if (w_we) mem[w_addr] <= w_wdata;
    r_rdata <= mem[w_addr];
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_state        <= CPU_OWN;
      r_wd           <= '0;
      r_block        <= 1'b0;
      r_timeout      <= 1'b0;
      r_hs_addr_last <= '0;
      r_cpu_pend     <= 1'b0;
      r_hs_pend      <= 1'b0;
      r_hs_oow       <= 1'b0;
      r_cpu_hold     <= 8'h00;
      r_hs_hold      <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_wd    <= (r_state == HS_OWN) ? r_wd + WD_W'(1) : '0;
      if (w_fire) r_timeout <= 1'b1;
      // After a watchdog expiry the engine must drop its request before it
      // may be granted again.
      if (!hs_req)     r_block <= 1'b0;
      else if (w_fire) r_block <= 1'b1;
      if (r_state == HS_OWN) r_hs_addr_last <= w_hs_off[ADDR_W-1:0];
      r_cpu_pend <= (r_state == CPU_OWN) && cpu_cs && !cpu_wr;
      r_hs_pend  <= (r_state == HS_OWN) && !hs_write;
      r_hs_oow   <= !w_hs_in;
      if (r_cpu_pend) r_cpu_hold <= r_rdata;
      if (r_hs_pend)  r_hs_hold  <= w_hs_rd;
    end
  end

  assign w_hs_rd     = r_hs_oow ? 8'h00 : r_rdata;
  assign cpu_dout    = r_cpu_pend ? r_rdata : r_cpu_hold;
  assign hs_data_out = r_hs_pend ? w_hs_rd : r_hs_hold;
  assign cpu_wait    = (r_state != CPU_OWN);
  assign hs_grant    = (r_state == HS_OWN);
  assign hs_timeout  = r_timeout;

endmodule
`default_nettype wire
